frame_sync_ctrl: RTL
====================

// Module: frame_sync_ctrl
// PURPOSE
//  Frame-alignment controller sequenced by the byte-wide pattern detector. It consumes the
//  detector's one-cycle sync pulse and runs a hunt/verify/lock flywheel over fixed-length frames.
//  It emits the aligned payload stream with start-of-frame and valid markers, plus lock status
//  and miss statistics. Sits between the detector/serdes byte stream and the frame parser.
// PARAMETERS
//  FRAME_LEN   64  bytes per frame incl. sync word; legal range >= SYNC_LEN+4
//  SYNC_LEN    4   sync-word length in bytes; must match the detector PATTERN width/8
//  LOCK_CNT    2   consecutive on-grid syncs after the seed needed to enter LOCKED (>=1)
//  UNLOCK_CNT  3   consecutive missed syncs in LOCKED that force HUNT (>=1)
//  CNT_W       16  width of saturating miss counter
// PORTS
//  i_clk          in   1      clock
//  i_rst_n        in   1      asynchronous active-low reset
//  i_enable       in   1      0 = force HUNT, suppress outputs
//  i_data         in   8      byte stream, one byte per clock (same stream fed to detector)
//  i_sync         in   1      detector pulse: previous-cycle byte was last sync byte
//  i_clr_cnt      in   1      synchronous clear of o_miss_total
//  o_data         out  8      i_data delayed one cycle
//  o_valid        out  1      o_data is a payload byte of a locked frame
//  o_sof          out  1      o_data is first payload byte of a frame
//  o_locked       out  1      state == LOCKED
//  o_state        out  2      00 HUNT, 01 VERIFY, 10 LOCKED (11 unused)
//  o_miss_total   out  CNT_W  saturating count of missed syncs while LOCKED
// BEHAVIOUR
//  Reset: clock and reset are single-domain; reset asserts asynchronously and deasserts synchronously.
//  - Reset value: every output is 0, state is HUNT, and all internal counters are 0.
//  - Reset mid-frame drops lock immediately.
//  Position counter p (0..FRAME_LEN-1):
//  - p is set to 1 the cycle after an accepted seed sync.
//  - Otherwise p increments each cycle and wraps from FRAME_LEN-1 to 0.
//  - p==0 is the expected sync slot. Cycle t has p==0 exactly when it is a whole multiple of
//    FRAME_LEN after the seed.
//  HUNT:
//  - Any i_sync seeds the grid: it goes to VERIFY, hit count is 1, and the grid is aligned to that cycle.
//  VERIFY:
//  - i_sync at p!=0 is ignored.
//  - At p==0 with i_sync, hit count increments. Reaching LOCK_CNT+1 goes to LOCKED in that same
//    cycle, and that frame's payload is output.
//  - At p==0 without i_sync, go to HUNT. In that same cycle, an i_sync at p==0 is not possible
//    (that case is a hit).
//  LOCKED (flywheel):
//  - i_sync at p!=0 is ignored, i.e. payload emulation of the sync word.
//  - At p==0 with i_sync, the miss run is cleared to 0.
//  - At p==0 without i_sync: the miss run increments and o_miss_total increments (saturating at
//    2^CNT_W-1).
//    - If the run reaches UNLOCK_CNT, go to HUNT and output nothing for that frame.
//    - Otherwise stay LOCKED and output payload on the projected grid.
//  Payload window:
//  - Bytes at input cycles with p in [0, FRAME_LEN-SYNC_LEN-1], relative to the accepted sync
//    cycle (p==0), are payload. The remaining SYNC_LEN bytes are the next sync word and are never
//    marked valid.
//  - Output registration: o_data, o_valid and o_sof are registered with 1-cycle latency.
//    - o_valid = 1 only for payload bytes while LOCKED.
//    - o_sof = 1 only with p==0 and o_valid.
//  - A transition to HUNT or VERIFY deasserts o_valid on the next output cycle. A partial frame is
//    truncated with no end marker.
//  - A transition to LOCKED starts o_valid at the frame beginning at the locking sync.
//  i_enable=0:
//  - Synchronous HUNT; hit and miss runs are cleared; o_valid, o_sof and o_locked are 0.
//  - o_miss_total is held.
//  i_clr_cnt:
//  - Clears o_miss_total next cycle. If it coincides with a miss, the clear wins (result 0).
// TESTING  (FRAME_LEN=16, LOCK_CNT=2, UNLOCK_CNT=3, CNT_W=4)
//  1 Syncs at cycles 20,36,52:
//    - o_state reads 01 from cycle 21 and 10 from cycle 53.
//    - o_sof=1 at cycle 53 with o_data = i_data@52.
//    - o_valid is high for 12 cycles (53..64) and low for 65..68.
//  2 Locked, extra i_sync at off-grid cycle 60: no state change, o_sof/o_valid unaffected, o_miss_total=0.
//  3 Locked, suppress syncs at 68 and 84, restore at 100:
//    - Stays LOCKED; o_miss_total=2.
//    - Flywheel frames at 69 and 85 are still marked valid.
//    - Suppressing 3 in a row makes o_state=00 and drops o_valid after the third miss.
//  4 VERIFY with a missing 2nd sync -> HUNT. Then a new sync at off-grid cycle 45 re-seeds
//    (o_state=01 at 46), and lock is achieved at 78.
//  5 Miss counter:
//    - Intermittent misses saturate o_miss_total at 15.
//    - i_clr_cnt asserted in a miss cycle -> o_miss_total=0.
//  6 i_rst_n pulsed low mid-payload while locked: all outputs 0 asynchronously; re-lock requires
//    3 syncs. i_enable=0 for 1 cycle -> HUNT, and o_miss_total is retained.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctrl
//   Frame-alignment flywheel driven by an upstream sync-word detector. A sync
//   pulse seeds a frame grid (HUNT -> VERIFY). LOCK_CNT further on-grid syncs
//   take it to LOCKED. While LOCKED, UNLOCK_CNT consecutive missed syncs drop
//   it back to HUNT. The aligned byte stream is re-emitted one cycle late, with
//   payload-valid and start-of-frame markers.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_enable        0 forces HUNT and suppresses payload output
//   i_data[7:0]     byte stream, one byte per clock
//   i_sync          detector pulse: the previous byte closed a sync word
//   i_clr_cnt       clears o_miss_total (wins over a simultaneous miss)
//   o_data[7:0]     i_data delayed by one cycle
//   o_valid         o_data is a payload byte of a locked frame
//   o_sof           o_data is the first payload byte of a frame
//   o_locked        state is LOCKED
//   o_state[1:0]    00 HUNT, 01 VERIFY, 10 LOCKED
//   o_miss_total    saturating count of syncs missed while LOCKED
// -----------------------------------------------------------------------------
module frame_sync_ctrl #(
    parameter int FRAME_LEN  = 64,
    parameter int SYNC_LEN   = 4,
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [7:0]       i_data,
    input  logic             i_sync,
    input  logic             i_clr_cnt,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_locked,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_miss_total
);

    localparam int P_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HIT_W  = $clog2(LOCK_CNT + 2);
    localparam int MISS_W = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

    localparam logic [P_W-1:0]    P_LAST    = P_W'(FRAME_LEN - 1);
    localparam logic [P_W-1:0]    PAY_LEN   = P_W'(FRAME_LEN - SYNC_LEN);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t            state;
    logic [P_W-1:0]    p;         // position within the frame, 0 = sync slot
    logic [HIT_W-1:0]  hits;
    logic [MISS_W-1:0] miss_run;

    logic at_slot;
    logic in_payload;

    assign at_slot    = (p == '0);
    assign in_payload = (p < PAY_LEN);

    assign o_state  = state;
    assign o_locked = (state == LOCKED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= HUNT;
            p            <= '0;
            hits         <= '0;
            miss_run     <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_miss_total <= '0;
        end else begin
            o_data  <= i_data;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            p       <= (p == P_LAST) ? '0 : p + 1'b1;

            if (!i_enable) begin
                state    <= HUNT;
                hits     <= '0;
                miss_run <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        // The seed cycle itself is slot 0 of the new grid.
                        if (i_sync) begin
                            state <= VERIFY;
                            hits  <= HIT_W'(1);
                            p     <= P_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (at_slot) begin
                            if (i_sync) begin
                                hits <= hits + 1'b1;
                                // Locking frame is emitted starting at its own sync slot.
                                if (hits == HIT_LAST) begin
                                    state    <= LOCKED;
                                    miss_run <= '0;
                                    o_valid  <= 1'b1;
                                    o_sof    <= 1'b1;
                                end
                            end else begin
                                state <= HUNT;
                                hits  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (at_slot) begin
                            if (i_sync) begin
                                miss_run <= '0;
                                o_valid  <= 1'b1;
                                o_sof    <= 1'b1;
                            end else begin
                                if (o_miss_total != '1)
                                    o_miss_total <= o_miss_total + 1'b1;
                                if (miss_run == MISS_LAST) begin
                                    // Final miss: this frame is not emitted at all.
                                    state    <= HUNT;
                                    miss_run <= '0;
                                    hits     <= '0;
                                end else begin
                                    // Flywheel: keep emitting on the projected grid.
                                    miss_run <= miss_run + 1'b1;
                                    o_valid  <= 1'b1;
                                    o_sof    <= 1'b1;
                                end
                            end
                        end else begin
                            o_valid <= in_payload;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        hits  <= '0;
                    end
                endcase
            end

            // Placed last so that a clear beats a same-cycle miss increment.
            if (i_clr_cnt)
                o_miss_total <= '0;
        end
    end

endmodule
